// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA output stage.
package vga_pkg;

    typedef logic [3:0]  pixel_t;
    typedef logic [18:0] fb_addr_t;

    // Per-pixel control bits that travel alongside the frame-buffer read.
    // The all-zero value means "blank, no sync active".
    typedef struct packed {
        logic first;    // pixel (0,0) of the frame
        logic vs_act;   // vertical sync pulse region
        logic hs_act;   // horizontal sync pulse region
        logic visible;  // inside the active picture
    } pix_ctl_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int RD_LAT_DEF   = 1;
    localparam bit SYNC_POL_DEF = 1'b0;

    // Total clocks per line, or total lines per frame, from the four segments.
    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_if.sv
// Frame-buffer read port and VGA pin bundle.
interface vga_if;
    import vga_pkg::*;

    fb_addr_t rd_addr;
    pixel_t   rd_data;
    pixel_t   vga_r;
    pixel_t   vga_g;
    pixel_t   vga_b;
    logic     vga_hsync;
    logic     vga_vsync;
    logic     frame_start;

    // Video source: issues reads, drives the pins.
    modport master (
        output rd_addr,
        input  rd_data,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hsync,
        output vga_vsync,
        output frame_start
    );

    // Frame buffer / display side.
    modport slave (
        input  rd_addr,
        output rd_data,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hsync,
        input  vga_vsync,
        input  frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters and the stage-0 position decodes.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic     clk25,
    input  logic     rst_n,
    output pix_ctl_t ctl,   // decodes for the current (h,v)
    output logic     last   // (H_TOTAL-1, V_TOTAL-1): last clock of the frame
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_wrap;
    logic          v_wrap;

    // Next raster position: h wraps every line, v advances on the h wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        h_wrap  = (h_cnt_q == HW'(H_TOTAL - 1));
        v_wrap  = (v_cnt_q == VW'(V_TOTAL - 1));
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Raster counter registers; reset parks the beam at (0,0).
    always_ff @(posedge clk25 or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Region decodes for the position held in the counters this clock.
    always_comb begin
        ctl         = '0;
        ctl.visible = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        ctl.hs_act  = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                      (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
        ctl.vs_act  = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                      (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
        ctl.first   = (h_cnt_q == '0) && (v_cnt_q == '0);
        last        = h_wrap && v_wrap;
    end

endmodule

// File: rtl/vga_out.sv
// VGA output stage: frame-buffer address generation, read-latency
// compensation of the control bits, and the registered pin outputs.
module vga_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,   // 1..3
    parameter bit SYNC_POL = SYNC_POL_DEF  // active level of both syncs
) (
    input logic   clk25,
    input logic   rst_n,
    vga_if.master vif
);

    // Control bits must wait one clock for the address register plus
    // RD_LAT clocks for the buffer, then meet rd_data at the output register.
    localparam int DLY = RD_LAT + 1;

    pix_ctl_t           ctl0;
    logic               last0;
    pix_ctl_t           ctl_out;
    fb_addr_t           rd_addr_q, rd_addr_d;
    pix_ctl_t [DLY-1:0] dly_q, dly_d;
    pixel_t             pix_q, pix_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               fs_q, fs_d;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk25 (clk25),
        .rst_n (rst_n),
        .ctl   (ctl0),
        .last  (last0)
    );

    assign ctl_out = dly_q[DLY-1];

    // Read address: one step per visible pixel, held in blanking, and
    // restarted at 0 so the first pixel of each frame reads address 0.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (last0) begin
            rd_addr_d = '0;
        end else if (ctl0.visible) begin
            rd_addr_d = ctl0.first ? '0 : rd_addr_q + fb_addr_t'(1);
        end
    end

    // Delay line shift and output formatting of the aligned pixel.
    always_comb begin
        dly_d   = {dly_q[DLY-2:0], ctl0};
        // Blanked pixels select a constant, so garbage on rd_data never reaches the pins.
        pix_d   = ctl_out.visible ? vif.rd_data : '0;
        hsync_d = ctl_out.hs_act ? SYNC_POL : ~SYNC_POL;
        vsync_d = ctl_out.vs_act ? SYNC_POL : ~SYNC_POL;
        fs_d    = ctl_out.first;
    end

    // Address, delay-line and pin registers.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            // NOTE: the delay line is reset too, otherwise a stale sync or visible bit could leak out after a mid-frame reset.
            dly_q     <= '0;
            pix_q     <= '0;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            fs_q      <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            dly_q     <= dly_d;
            pix_q     <= pix_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            fs_q      <= fs_d;
        end
    end

    assign vif.rd_addr     = rd_addr_q;
    assign vif.vga_r       = pix_q;
    assign vif.vga_g       = pix_q;
    assign vif.vga_b       = pix_q;
    assign vif.vga_hsync   = hsync_q;
    assign vif.vga_vsync   = vsync_q;
    assign vif.frame_start = fs_q;

endmodule

// File: tb/tb_vga_out.sv
// Self-checking bench for vga_out: a full-size instance (RD_LAT=1,
// active-low syncs) and a reduced-raster instance (RD_LAT=2, active-high
// syncs) run side by side against a position-based reference model.
module tb_vga_out;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        int pipe;
        bit pol;
    } cfg_t;

    typedef struct {
        logic [18:0] addr;
        logic [3:0]  pix;
        logic        hs, vs, fs;
    } exp_t;

    typedef struct {
        int   k;         // clocks since reset release
        logic hs;
        logic fs;
        int   addr;      // expected rd_addr
        int   pix_addr;  // address of the pixel on the pins, -1 when blank
    } vec_t;

    localparam int NV = 13;

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 3, 1'b0};
    cfg_t cfg_b = '{24, 4, 6, 5, 10, 2, 2, 3, 4, 1'b1};

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    int          k_a, k_b;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  tbl [1024];
    logic [18:0] ma_q;
    logic [18:0] mb_q [2];
    logic [2:0]  mon_a, mon_b;
    vec_t        vecs [NV];

    vga_if vif_a ();
    vga_if vif_b ();

    vga_out u_a (
        .clk25 (clk),
        .rst_n (rst_a_n),
        .vif   (vif_a)
    );

    vga_out #(
        .H_ACTIVE (24), .H_FP (4), .H_SYNC (6), .H_BP (5),
        .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .RD_LAT   (2),  .SYNC_POL (1'b1)
    ) u_b (
        .clk25 (clk),
        .rst_n (rst_b_n),
        .vif   (vif_b)
    );

    always #20 clk = ~clk;

    assign mon_a = {vif_a.frame_start, vif_a.vga_vsync, vif_a.vga_hsync};
    assign mon_b = {vif_b.frame_start, vif_b.vga_vsync, vif_b.vga_hsync};

    // ---------------- reference model ----------------
    function automatic bit vis_at(input cfg_t c, input int s);
        int ht, vt, h, v;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        if (s < 0) return 1'b0;
        h = s % ht;
        v = (s / ht) % vt;
        return (h < c.ha) && (v < c.va);
    endfunction

    // Expected pins after k clocks since release (k = 0: in or just out of reset).
    function automatic exp_t model(input cfg_t c, input int k);
        exp_t e;
        int ht, vt, s, h, v;
        ht     = c.ha + c.hf + c.hs + c.hb;
        vt     = c.va + c.vf + c.vs + c.vb;
        e.addr = '0;
        e.pix  = '0;
        e.hs   = ~c.pol;
        e.vs   = ~c.pol;
        e.fs   = 1'b0;
        if (k >= 1) begin
            s = k - 1;
            h = s % ht;
            v = (s / ht) % vt;
            if (h == ht - 1 && v == vt - 1) e.addr = '0;
            else if (v < c.va)              e.addr = 19'(v * c.ha + ((h < c.ha) ? h : c.ha - 1));
            else                            e.addr = 19'(c.va * c.ha - 1);
        end
        if (k >= c.pipe) begin
            s = k - c.pipe;
            h = s % ht;
            v = (s / ht) % vt;
            if (h < c.ha && v < c.va) e.pix = tbl[10'(v * c.ha + h)];
            if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) e.hs = c.pol;
            if (v >= c.va + c.vf && v < c.va + c.vf + c.vs) e.vs = c.pol;
            e.fs = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    // ---------------- frame-buffer models ----------------
    always @(posedge clk or negedge rst_a_n)
        if (!rst_a_n) k_a <= 0; else k_a <= k_a + 1;

    always @(posedge clk or negedge rst_b_n)
        if (!rst_b_n) k_b <= 0; else k_b <= k_b + 1;

    always @(posedge clk) begin
        ma_q    <= vif_a.rd_addr;
        mb_q[0] <= vif_b.rd_addr;
        mb_q[1] <= mb_q[0];
    end

    // Return table data for visible pixels and 4'hF while the pixel is blank.
    always_comb begin
        vif_a.rd_data = vis_at(cfg_a, k_a + 1 - cfg_a.pipe) ? tbl[ma_q[9:0]] : 4'hF;
        vif_b.rd_data = vis_at(cfg_b, k_b + 1 - cfg_b.pipe) ? tbl[mb_q[1][9:0]] : 4'hF;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Continuous per-clock comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t ea, eb;
        ea = model(cfg_a, k_a);
        eb = model(cfg_b, k_b);
        check("a_addr",  32'(vif_a.rd_addr),     32'(ea.addr));
        check("a_r",     32'(vif_a.vga_r),       32'(ea.pix));
        check("a_g",     32'(vif_a.vga_g),       32'(ea.pix));
        check("a_b",     32'(vif_a.vga_b),       32'(ea.pix));
        check("a_hsync", 32'(vif_a.vga_hsync),   32'(ea.hs));
        check("a_vsync", 32'(vif_a.vga_vsync),   32'(ea.vs));
        check("a_fs",    32'(vif_a.frame_start), 32'(ea.fs));
        check("b_addr",  32'(vif_b.rd_addr),     32'(eb.addr));
        check("b_r",     32'(vif_b.vga_r),       32'(eb.pix));
        check("b_g",     32'(vif_b.vga_g),       32'(eb.pix));
        check("b_b",     32'(vif_b.vga_b),       32'(eb.pix));
        check("b_hsync", 32'(vif_b.vga_hsync),   32'(eb.hs));
        check("b_vsync", 32'(vif_b.vga_vsync),   32'(eb.vs));
        check("b_fs",    32'(vif_b.frame_start), 32'(eb.fs));
    end

    // Wait (bounded) for monitor bit bitn of an instance to equal val; returns k at that point.
    task automatic wait_bit(input bit inst, input int bitn, input logic val, input int bound,
                            input string name, output int k_seen);
        k_seen = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if ((inst ? mon_b[bitn] : mon_a[bitn]) === val) begin
                k_seen = inst ? k_b : k_a;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL %s: timeout after %0d clocks", name, bound);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_hs"},   32'(vif_a.vga_hsync),   32'(1));
        check({tag, "_vs"},   32'(vif_a.vga_vsync),   32'(1));
        check({tag, "_rgb"},  32'({vif_a.vga_r, vif_a.vga_g, vif_a.vga_b}), 32'(0));
        check({tag, "_addr"}, 32'(vif_a.rd_addr),     32'(0));
        check({tag, "_fs"},   32'(vif_a.frame_start), 32'(0));
    endtask

    task automatic check_reset_b(input string tag);
        check({tag, "_hs"},   32'(vif_b.vga_hsync),   32'(0));
        check({tag, "_vs"},   32'(vif_b.vga_vsync),   32'(0));
        check({tag, "_rgb"},  32'({vif_b.vga_r, vif_b.vga_g, vif_b.vga_b}), 32'(0));
        check({tag, "_addr"}, 32'(vif_b.rd_addr),     32'(0));
        check({tag, "_fs"},   32'(vif_b.frame_start), 32'(0));
    endtask

    // Full-size raster: table vectors, line timing, mid-frame reset.
    task automatic run_a();
        int kf1, kr, kf2, kk;
        logic [3:0] ep;
        for (int i = 0; i < NV; i++) begin
            while (k_a < vecs[i].k) @(negedge clk);
            ep = (vecs[i].pix_addr < 0) ? 4'h0 : tbl[10'(vecs[i].pix_addr)];
            check($sformatf("vec%0d_hs", i),   32'(vif_a.vga_hsync),   32'(vecs[i].hs));
            check($sformatf("vec%0d_vs", i),   32'(vif_a.vga_vsync),   32'(1));
            check($sformatf("vec%0d_fs", i),   32'(vif_a.frame_start), 32'(vecs[i].fs));
            check($sformatf("vec%0d_addr", i), 32'(vif_a.rd_addr),     32'(vecs[i].addr));
            check($sformatf("vec%0d_pix", i),  32'(vif_a.vga_r),       32'(ep));
        end
        wait_bit(1'b0, 0, 1'b0, 2000, "a_hs_fall", kf1);
        check("a_hs_fall", 32'(kf1), 32'(800 + 659));
        wait_bit(1'b0, 0, 1'b1, 200, "a_hs_rise", kr);
        check("a_hs_width", 32'(kr - kf1), 32'(96));
        wait_bit(1'b0, 0, 1'b0, 1000, "a_hs_fall2", kf2);
        check("a_hs_period", 32'(kf2 - kf1), 32'(800));
        while (k_a < 3 * 800 + 300) @(negedge clk);
        @(posedge clk);
        #10 rst_a_n = 1'b0;
        @(negedge clk);
        check_reset_a("a_midrst");
        repeat (5) @(posedge clk);
        #10 rst_a_n = 1'b1;
        wait_bit(1'b0, 0, 1'b0, 2000, "a_hs_after_rst", kk);
        check("a_hs_after_rst", 32'(kk), 32'(659));
    endtask

    // Reduced raster with RD_LAT=2: frame timing, address range, mid-frame reset.
    task automatic run_b();
        int k0, k1, k2, k3, k4, k5;
        int mx;
        wait_bit(1'b1, 2, 1'b1, 200, "b_fs_first", k0);
        check("b_fs_first", 32'(k0), 32'(4));
        wait_bit(1'b1, 1, 1'b1, 1000, "b_vs_start", k1);
        check("b_vs_start", 32'(k1), 32'(4 + 12 * 39));
        wait_bit(1'b1, 1, 1'b0, 200, "b_vs_end", k2);
        check("b_vs_width", 32'(k2 - k1), 32'(2 * 39));
        wait_bit(1'b1, 2, 1'b1, 1000, "b_fs_next", k3);
        check("b_fs_period", 32'(k3 - k0), 32'(663));
        mx = 0;
        repeat (663) begin
            @(negedge clk);
            if (int'(vif_b.rd_addr) > mx) mx = int'(vif_b.rd_addr);
        end
        check("b_addr_max", 32'(mx), 32'(239));
        while (k_b < 2 * 663 + 5 * 39 + 12) @(negedge clk);
        @(posedge clk);
        #10 rst_b_n = 1'b0;
        @(negedge clk);
        check_reset_b("b_midrst");
        repeat (5) @(posedge clk);
        #10 rst_b_n = 1'b1;
        wait_bit(1'b1, 2, 1'b1, 100, "b_fs_after_rst", k4);
        check("b_fs_after_rst", 32'(k4), 32'(4));
        wait_bit(1'b1, 2, 1'b1, 800, "b_fs_after_rst2", k5);
        check("b_fs_after_rst2", 32'(k5), 32'(667));
    endtask

    initial begin
        vecs[0]  = '{1,   1'b1, 1'b0, 0,   -1};
        vecs[1]  = '{2,   1'b1, 1'b0, 1,   -1};
        vecs[2]  = '{3,   1'b1, 1'b1, 2,   0};
        vecs[3]  = '{4,   1'b1, 1'b0, 3,   1};
        vecs[4]  = '{642, 1'b1, 1'b0, 639, 639};
        vecs[5]  = '{643, 1'b1, 1'b0, 639, -1};
        vecs[6]  = '{658, 1'b1, 1'b0, 639, -1};
        vecs[7]  = '{659, 1'b0, 1'b0, 639, -1};
        vecs[8]  = '{754, 1'b0, 1'b0, 639, -1};
        vecs[9]  = '{755, 1'b1, 1'b0, 639, -1};
        vecs[10] = '{800, 1'b1, 1'b0, 639, -1};
        vecs[11] = '{801, 1'b1, 1'b0, 640, -1};
        vecs[12] = '{803, 1'b1, 1'b0, 642, 640};
        for (int i = 0; i < 1024; i++) tbl[i] = 4'($urandom);

        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        #1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a("a_rst");
        check_reset_b("b_rst");
        @(posedge clk);
        #10;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        fork
            run_a();
            run_b();
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
